// File: rtl/midi_note_alloc.sv
// midi_note_alloc: MIDI byte parser feeding a DDS voice slot allocator.
// Ports: i_clk, i_res (async, active-high); i_midi_data/i_midi_valid/o_ready
// byte input; o_note_addr/o_note_en/o_add_val/o_note_wren DDS note RAM write;
// o_overflow pulses when a Note On finds no free slot.
// Build option: define MIDI_OMNI_EN to accept all 16 channels and match
// slots on note plus channel (default: single channel P_MIDI_CH, note only).
module midi_note_alloc #(
    parameter logic [3:0] P_MIDI_CH = 4'd0,
    parameter int         P_SLOTS   = 64
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic [7:0]  i_midi_data,
    input  logic        i_midi_valid,
    output logic        o_ready,
    output logic [5:0]  o_note_addr,
    output logic        o_note_en,
    output logic [23:0] o_add_val,
    output logic        o_note_wren,
    output logic        o_overflow
);

    typedef enum logic [1:0] {WAIT_STAT, WAIT_D1, WAIT_D2} pstate_t;
    typedef enum logic [1:0] {IDLE, SCAN, WRITE, INIT} astate_t;

    localparam logic [5:0] LAST = 6'(P_SLOTS - 1);

    // Phase increment for note n at a 562.5 kHz DDS with a 26-bit phase
    // fraction; evaluated at elaboration only.
    function automatic logic [23:0] lut_val(input int n);
        real f;
        int  d;
        f = 29527900160.0 / 562500.0;
        d = n - 69;
        while (d >= 12) begin
            f = f * 2.0;
            d = d - 12;
        end
        while (d < 0) begin
            f = f / 2.0;
            d = d + 12;
        end
        for (int i = 0; i < d; i++) begin
            f = f * 1.0594630943592953;
        end
        return 24'($rtoi(f + 0.5));
    endfunction

    logic [23:0] lut [128];

    for (genvar g = 0; g < 128; g++) begin : g_lut
        localparam logic [23:0] LV = lut_val(g);
        assign lut[g] = LV;
    end

    pstate_t pstate;
    astate_t astate;
    logic [7:0] rs;
    logic       rs_valid;
    logic [6:0] d1;

    logic [P_SLOTS-1:0]      slot_valid;
    logic [P_SLOTS-1:0][6:0] slot_note;
`ifdef MIDI_OMNI_EN
    logic [P_SLOTS-1:0][3:0] slot_ch;
    logic [3:0]              cur_ch;
`endif

    logic [6:0] cur_note;
    logic       cur_on;
    logic [5:0] scan_idx;
    logic [5:0] init_idx;
    logic       match_found;
    logic       free_found;
    logic [5:0] match_idx;
    logic [5:0] free_idx;

    logic       accept;
    logic       is_rt;
    logic       is_sys;
    logic       one_data;
    logic       ch_ok;
    logic       start;
    logic       hit;
    logic       m_found;
    logic       f_found;
    logic [5:0] m_idx;
    logic [5:0] f_idx;

    assign o_ready = (astate == IDLE);

    always_comb begin
        accept   = i_midi_valid && o_ready;
        is_rt    = (i_midi_data[7:3] == 5'b11111);
        is_sys   = (i_midi_data[7:3] == 5'b11110);
        // 0xCn and 0xDn carry a single data byte
        one_data = (rs[7:5] == 3'b110);
`ifdef MIDI_OMNI_EN
        ch_ok    = 1'b1;
`else
        ch_ok    = (rs[3:0] == P_MIDI_CH);
`endif
        // final data byte of a Note On / Note Off on an accepted channel
        start    = accept && !i_midi_data[7] && (pstate == WAIT_D2)
                && (rs[7:5] == 3'b100) && ch_ok;
        hit      = slot_valid[scan_idx] && (slot_note[scan_idx] == cur_note);
`ifdef MIDI_OMNI_EN
        hit      = hit && (slot_ch[scan_idx] == cur_ch);
`endif
        // running results including the slot visited this cycle
        m_found  = match_found || hit;
        m_idx    = match_found ? match_idx : scan_idx;
        f_found  = free_found || !slot_valid[scan_idx];
        f_idx    = free_found ? free_idx : scan_idx;
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            pstate      <= WAIT_STAT;
            rs          <= '0;
            rs_valid    <= 1'b0;
            d1          <= '0;
            astate      <= INIT;
            init_idx    <= '0;
            scan_idx    <= '0;
            cur_note    <= '0;
            cur_on      <= 1'b0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            slot_valid  <= '0;
            slot_note   <= '0;
`ifdef MIDI_OMNI_EN
            slot_ch     <= '0;
            cur_ch      <= '0;
`endif
            o_note_addr <= '0;
            o_note_en   <= 1'b0;
            o_add_val   <= '0;
            o_note_wren <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_note_wren <= 1'b0;
            o_overflow  <= 1'b0;

            if (accept) begin
                if (is_rt) begin
                    // real-time bytes pass through without side effects
                end else if (is_sys) begin
                    rs_valid <= 1'b0;
                    pstate   <= WAIT_STAT;
                end else if (i_midi_data[7]) begin
                    rs       <= i_midi_data;
                    rs_valid <= 1'b1;
                    pstate   <= WAIT_D1;
                end else begin
                    case (pstate)
                        WAIT_STAT: begin
                            if (rs_valid && !one_data) begin
                                d1     <= i_midi_data[6:0];
                                pstate <= WAIT_D2;
                            end
                        end
                        WAIT_D1: begin
                            if (one_data) begin
                                pstate <= WAIT_STAT;
                            end else begin
                                d1     <= i_midi_data[6:0];
                                pstate <= WAIT_D2;
                            end
                        end
                        WAIT_D2: pstate <= WAIT_STAT;
                        default: pstate <= WAIT_STAT;
                    endcase
                end
            end

            case (astate)
                INIT: begin
                    o_note_addr <= init_idx;
                    o_note_en   <= 1'b0;
                    o_add_val   <= '0;
                    o_note_wren <= 1'b1;
                    init_idx    <= init_idx + 6'd1;
                    // WRITE holds o_ready low while the last clear is shown
                    if (init_idx == LAST) begin
                        astate <= WRITE;
                    end
                end
                IDLE: begin
                    if (start) begin
                        cur_note    <= d1;
                        cur_on      <= rs[4] && (i_midi_data[6:0] != 7'd0);
`ifdef MIDI_OMNI_EN
                        cur_ch      <= rs[3:0];
`endif
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        astate      <= SCAN;
                    end
                end
                SCAN: begin
                    match_found <= m_found;
                    match_idx   <= m_idx;
                    free_found  <= f_found;
                    free_idx    <= f_idx;
                    scan_idx    <= scan_idx + 6'd1;
                    if (scan_idx == LAST) begin
                        astate <= WRITE;
                        if (cur_on) begin
                            if (m_found) begin
                                o_note_addr <= m_idx;
                                o_note_en   <= 1'b1;
                                o_add_val   <= lut[cur_note];
                                o_note_wren <= 1'b1;
                            end else if (f_found) begin
                                o_note_addr           <= f_idx;
                                o_note_en             <= 1'b1;
                                o_add_val             <= lut[cur_note];
                                o_note_wren           <= 1'b1;
                                slot_valid[f_idx]     <= 1'b1;
                                slot_note[f_idx]      <= cur_note;
`ifdef MIDI_OMNI_EN
                                slot_ch[f_idx]        <= cur_ch;
`endif
                            end else begin
                                o_overflow <= 1'b1;
                            end
                        end else if (m_found) begin
                            o_note_addr       <= m_idx;
                            o_note_en         <= 1'b0;
                            o_add_val         <= '0;
                            o_note_wren       <= 1'b1;
                            slot_valid[m_idx] <= 1'b0;
                        end
                    end
                end
                WRITE: astate <= IDLE;
                default: astate <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_note_alloc.sv
// tb_midi_note_alloc: self-checking bench for midi_note_alloc (default build).
// Directed scenarios plus randomized MIDI traffic against a slot-table model.
module tb_midi_note_alloc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready;
    logic [5:0]  addr;
    logic        en;
    logic [23:0] add;
    logic        wren;
    logic        ovf;

    midi_note_alloc dut (
        .i_clk        (clk),
        .i_res        (rst),
        .i_midi_data  (data),
        .i_midi_valid (valid),
        .o_ready      (ready),
        .o_note_addr  (addr),
        .o_note_en    (en),
        .o_add_val    (add),
        .o_note_wren  (wren),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    typedef logic [71:0] sig_t;

    int total  = 0;
    int passed = 0;

    // model: slot table and running status of the sent stream
    bit         mv [64];
    int         mn [64];
    logic [7:0] mrs;
    bit         mrs_ok;

    function automatic logic [23:0] lut_model(input int n);
        real hz;
        hz = 440.0 * (2.0 ** ((n - 69) / 12.0));
        return 24'($rtoi(hz * 67108864.0 / 562500.0 + 0.5));
    endfunction

    // signature: {ready-low cycles, ready at end, writes, write cycle,
    //             addr, en, add_val, overflow pulses, overflow cycle}
    function automatic sig_t sig_write(input logic [5:0] a, input logic e,
                                       input logic [23:0] v);
        return {8'd65, 1'b1, 8'd1, 8'd65, a, e, v, 8'd0, 8'd0};
    endfunction

    function automatic sig_t sig_ovf();
        return {8'd65, 1'b1, 8'd0, 8'd0, 6'd0, 1'b0, 24'd0, 8'd1, 8'd65};
    endfunction

    function automatic sig_t sig_scan();
        return {8'd65, 1'b1, 8'd0, 8'd0, 6'd0, 1'b0, 24'd0, 8'd0, 8'd0};
    endfunction

    function automatic sig_t sig_none();
        return {8'd0, 1'b1, 8'd0, 8'd0, 6'd0, 1'b0, 24'd0, 8'd0, 8'd0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            mn[i] = 0;
        end
        mrs_ok = 1'b0;
        mrs    = 8'h00;
    endtask

    task automatic model_apply(input bit on, input int note, output sig_t s);
        int m;
        int f;
        m = -1;
        f = -1;
        for (int i = 0; i < 64; i++) begin
            if (m < 0 && mv[i] && mn[i] == note) m = i;
            if (f < 0 && !mv[i]) f = i;
        end
        if (on) begin
            if (m >= 0) begin
                s = sig_write(6'(m), 1'b1, lut_model(note));
            end else if (f >= 0) begin
                mv[f] = 1'b1;
                mn[f] = note;
                s = sig_write(6'(f), 1'b1, lut_model(note));
            end else begin
                s = sig_ovf();
            end
        end else if (m >= 0) begin
            mv[m] = 1'b0;
            s = sig_write(6'(m), 1'b0, 24'd0);
        end else begin
            s = sig_scan();
        end
    endtask

    // Called on the falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            $display("FAIL ready_timeout got=%b want=1", ready);
            return;
        end
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        if (b[7:3] == 5'b11110) begin
            mrs_ok = 1'b0;
        end else if (b[7] && b[7:3] != 5'b11111) begin
            mrs    = b;
            mrs_ok = 1'b1;
        end
    endtask

    // Watches cycles T+1..T+66 after a final byte; k=1 is the current edge.
    task automatic observe(output sig_t s);
        int rl, wc, wk, oc, ok;
        logic [5:0]  a;
        logic        e;
        logic [23:0] v;
        logic        re;
        rl = 0; wc = 0; wk = 0; oc = 0; ok = 0;
        a = '0; e = 1'b0; v = '0; re = 1'b0;
        for (int k = 1; k <= 66; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 65 && !ready) rl++;
            if (k == 66) re = ready;
            if (wren) begin
                wc++;
                wk = k;
                a  = addr;
                e  = en;
                v  = add;
            end
            if (ovf) begin
                oc++;
                ok = k;
            end
        end
        s = {8'(rl), re, 8'(wc), 8'(wk), a, e, v, 8'(oc), 8'(ok)};
    endtask

    task automatic do_reset();
        int n;
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            $display("FAIL init_timeout got=%b want=1", ready);
        end
    endtask

    task automatic test_reset();
        int wc, first;
        bit seq_ok, zero_ok, rdy_ok;
        sig_t got, exp;
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ready, wren, ovf, addr, en, add} !== 35'd0)
            $display("FAIL reset_outputs got=%h want=0",
                     {ready, wren, ovf, addr, en, add});
        else passed++;
        rst = 1'b0;
        model_reset();
        wc = 0; first = -1;
        seq_ok = 1'b1; zero_ok = 1'b1; rdy_ok = 1'b1;
        for (int k = 1; k <= 80 && first < 0; k++) begin
            @(negedge clk);
            if (wren) begin
                if (addr !== 6'(wc)) seq_ok = 1'b0;
                if (en !== 1'b0 || add !== 24'd0) zero_ok = 1'b0;
                if (ready) rdy_ok = 1'b0;
                wc++;
            end
            if (ready && first < 0) first = k;
        end
        total++;
        if (wc != 64) $display("FAIL init_count got=%0d want=64", wc);
        else passed++;
        total++;
        if (!seq_ok) $display("FAIL init_addr_seq got=0 want=1");
        else passed++;
        total++;
        if (!zero_ok) $display("FAIL init_data got=0 want=1");
        else passed++;
        total++;
        if (!rdy_ok || first != 65)
            $display("FAIL init_ready got=%0d/%0b want=65/1", first, rdy_ok);
        else passed++;

        // a used slot is forgotten after a mid-scan reset
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
        model_apply(1'b1, 69, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL reset_pre_note got=%h want=%h", got, exp);
        else passed++;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({ready, wren, ovf, addr, en, add} !== 35'd0)
            $display("FAIL reset_async got=%h want=0",
                     {ready, wren, ovf, addr, en, add});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 200 && !ready; n++) @(negedge clk);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        model_apply(1'b1, 60, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL reset_cleared_table got=%h want=%h", got, exp);
        else passed++;
    endtask

    task automatic test_basic();
        sig_t got, exp;
        do_reset();
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
        model_apply(1'b1, 69, exp);
        observe(got);
        total++;
        if (got !== sig_write(6'd0, 1'b1, 24'd52494))
            $display("FAIL note_on_a4 got=%h want=%h", got,
                     sig_write(6'd0, 1'b1, 24'd52494));
        else passed++;
        send_byte(8'h3C); send_byte(8'h40);
        model_apply(1'b1, 60, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL running_on_c4 got=%h want=%h", got, exp);
        else passed++;
        send_byte(8'h45); send_byte(8'h00);
        model_apply(1'b0, 69, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL vel0_off got=%h want=%h", got, exp);
        else passed++;
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h7F);
        model_apply(1'b0, 60, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL note_off got=%h want=%h", got, exp);
        else passed++;
    endtask

    task automatic test_rt_sysex();
        sig_t got, exp;
        do_reset();
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h45); send_byte(8'h64);
        model_apply(1'b1, 69, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL realtime_inserted got=%h want=%h", got, exp);
        else passed++;
        send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h40);
        model_apply(1'b1, 60, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL realtime_keeps_rs got=%h want=%h", got, exp);
        else passed++;
        send_byte(8'h90); send_byte(8'hF0); send_byte(8'h45); send_byte(8'h64);
        observe(got);
        total++;
        if (got !== sig_none()) $display("FAIL sysex_clears_rs got=%h want=%h",
                                         got, sig_none());
        else passed++;
    endtask

    task automatic test_channel();
        sig_t got, exp;
        do_reset();
        send_byte(8'h91); send_byte(8'h45); send_byte(8'h64);
        observe(got);
        total++;
        if (got !== sig_none()) $display("FAIL other_channel got=%h want=%h",
                                         got, sig_none());
        else passed++;
        send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
        model_apply(1'b1, 69, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL own_channel got=%h want=%h", got, exp);
        else passed++;
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h64);
        observe(got);
        total++;
        if (got !== sig_none()) $display("FAIL control_change got=%h want=%h",
                                         got, sig_none());
        else passed++;
    endtask

    task automatic test_overflow();
        sig_t got, exp;
        int bad;
        do_reset();
        bad = 0;
        send_byte(8'h90);
        for (int n = 0; n < 64; n++) begin
            send_byte(8'(n)); send_byte(8'h01);
            model_apply(1'b1, n, exp);
            observe(got);
            total++;
            if (got !== exp) begin
                $display("FAIL fill_%0d got=%h want=%h", n, got, exp);
                bad++;
            end else passed++;
        end
        send_byte(8'd100); send_byte(8'h40);
        model_apply(1'b1, 100, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL overflow got=%h want=%h", got, exp);
        else passed++;
        total++;
        if ({addr, en, add} !== {6'd63, 1'b1, lut_model(63)})
            $display("FAIL hold_after_overflow got=%h want=%h",
                     {addr, en, add}, {6'd63, 1'b1, lut_model(63)});
        else passed++;
        send_byte(8'h80); send_byte(8'h7F); send_byte(8'h00);
        model_apply(1'b0, 127, exp);
        observe(got);
        total++;
        if (got !== exp) $display("FAIL off_no_match got=%h want=%h", got, exp);
        else passed++;
    endtask

    task automatic test_random();
        sig_t got, exp;
        do_reset();
        for (int it = 0; it < 50; it++) begin
            int kind;
            int note;
            int vel;
            logic [7:0] st;
            kind = $urandom_range(0, 9);
            note = $urandom_range(60, 67);
            vel  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127);
            if (kind < 3) st = 8'h80;
            else if (kind < 7) st = 8'h90;
            else if (kind == 7) st = 8'h95;
            else if (kind == 8) st = 8'hB0;
            else st = 8'hC0;
            if (!(mrs_ok && mrs == st && $urandom_range(0, 1) == 1))
                send_byte(st);
            if ($urandom_range(0, 3) == 0) send_byte(8'hF8);
            send_byte(8'(note));
            if (st != 8'hC0) begin
                if ($urandom_range(0, 3) == 0) send_byte(8'hFA);
                send_byte(8'(vel));
            end
            if (st == 8'h80 || st == 8'h90)
                model_apply(st == 8'h90 && vel != 0, note, exp);
            else
                exp = sig_none();
            observe(got);
            total++;
            if (got !== exp)
                $display("FAIL random_%0d st=%h n=%0d v=%0d got=%h want=%h",
                         it, st, note, vel, got, exp);
            else passed++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_rt_sysex();
        test_channel();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
